// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master command engine: word-sized incrementing bursts with pipelined address/data phases.
// Macro AHB_MST_FIXED_BURST_EN selects fixed-length INCR4/8/16 hburst encodings for aligned commands.
module ahb_lite_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LEN    = 16
) (
  input  logic                  hclk_i,
  input  logic                  hrst_n_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic                  cmd_write_i,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [4:0]            cmd_len_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  wdata_valid_i,
  output logic                  wdata_ready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [ADDR_WIDTH-1:0] haddr_o,
  output logic [1:0]            htrans_o,
  output logic                  hwrite_o,
  output logic [2:0]            hsize_o,
  output logic [2:0]            hburst_o,
  output logic [3:0]            hprot_o,
  output logic                  hmasterlock_o,
  output logic [3:0]            hstrb_o,
  output logic [DATA_WIDTH-1:0] hwdata_o,
  input  logic [DATA_WIDTH-1:0] hrdata_i,
  input  logic                  hready_i,
  input  logic                  hresp_i
);

  // state | meaning
  // IDLE  | waiting for a command, cmd_ready_o high
  // ADDR  | issuing address beats (data phase of the previous beat may overlap)
  // DATA  | all address beats accepted, waiting on the final data phase
  // ERR   | error response seen, waiting for its second cycle
  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR} state_t;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'b000;
  localparam logic [2:0] BURST_INCR   = 3'b001;
`ifdef AHB_MST_FIXED_BURST_EN
  localparam logic [2:0] BURST_INCR4  = 3'b011;
  localparam logic [2:0] BURST_INCR8  = 3'b101;
  localparam logic [2:0] BURST_INCR16 = 3'b111;
`endif

  localparam logic [4:0] LEN_MAX = 5'(MAX_LEN);

  state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic                   write_q, write_d;
  logic [2:0]             burst_q, burst_d;
  logic [4:0]             rem_q, rem_d;
  logic                   first_q, first_d;
  logic                   hold_q, hold_d;
  logic                   dphase_q, dphase_d;
  logic [DATA_WIDTH-1:0]  hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic [4:0]             len_c;
  logic [2:0]             burst_c;
  logic                   beat_valid;
  logic                   beat_acc;
  logic                   dp_done;
  logic                   dp_err;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^cmd_addr_i[1:0];

  always_comb begin
    if (cmd_len_i == 5'd0) begin
      len_c = 5'd1;
    end else if (cmd_len_i > LEN_MAX) begin
      len_c = LEN_MAX;
    end else begin
      len_c = cmd_len_i;
    end
  end

  always_comb begin
    burst_c = BURST_INCR;
    if (len_c == 5'd1) begin
      burst_c = BURST_SINGLE;
    end
`ifdef AHB_MST_FIXED_BURST_EN
    else if (len_c == 5'd4 && cmd_addr_i[3:2] == 2'b00) begin
      burst_c = BURST_INCR4;
    end else if (len_c == 5'd8 && cmd_addr_i[4:2] == 3'b000) begin
      burst_c = BURST_INCR8;
    end else if (len_c == 5'd16 && cmd_addr_i[5:2] == 4'b0000) begin
      burst_c = BURST_INCR16;
    end
`endif
  end

  // A write beat already on the bus stays issued through wait states even if the source drops valid.
  assign beat_valid = (state_q == S_ADDR) && (!write_q || hold_q || wdata_valid_i);
  assign beat_acc   = beat_valid && hready_i;
  assign dp_done    = dphase_q && hready_i && !hresp_i;
  assign dp_err     = dphase_q && hresp_i;

  always_comb begin
    htrans_o = TR_IDLE;
    if (beat_valid) begin
      htrans_o = first_q ? TR_NONSEQ : TR_SEQ;
    end else if (state_q == S_ADDR) begin
      htrans_o = first_q ? TR_IDLE : TR_BUSY;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    write_d  = write_q;
    burst_d  = burst_q;
    rem_d    = rem_q;
    first_d  = first_q;
    hold_d   = 1'b0;
    dphase_d = dphase_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          addr_d   = {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
          write_d  = cmd_write_i;
          burst_d  = burst_c;
          rem_d    = len_c;
          first_d  = 1'b1;
          dphase_d = 1'b0;
          state_d  = S_ADDR;
        end
      end
      S_ADDR, S_DATA: begin
        if (dp_done) begin
          dphase_d = 1'b0;
          if (!write_q) begin
            rdata_d  = hrdata_i;
            rvalid_d = 1'b1;
          end
        end
        if (dp_err) begin
          dphase_d = 1'b0;
          if (hready_i) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = S_ERR;
          end
        end else if (state_q == S_ADDR) begin
          hold_d = beat_valid && !hready_i;
          if (beat_acc) begin
            addr_d   = addr_q + ADDR_WIDTH'(4);
            first_d  = 1'b0;
            rem_d    = rem_q - 5'd1;
            dphase_d = 1'b1;
            if (write_q) begin
              hwdata_d = wdata_i;
            end
            if (rem_q == 5'd1) begin
              state_d = S_DATA;
            end
          end
        end else if (dp_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_ERR: begin
        if (hready_i) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge hclk_i or negedge hrst_n_i) begin
    if (!hrst_n_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      write_q  <= 1'b0;
      burst_q  <= BURST_SINGLE;
      rem_q    <= 5'd0;
      first_q  <= 1'b0;
      hold_q   <= 1'b0;
      dphase_q <= 1'b0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      write_q  <= write_d;
      burst_q  <= burst_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      hold_q   <= hold_d;
      dphase_q <= dphase_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready_o   = hrst_n_i && (state_q == S_IDLE);
  assign wdata_ready_o = beat_acc && write_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign haddr_o       = addr_q;
  assign hwrite_o      = write_q;
  assign hsize_o       = 3'b010;
  assign hburst_o      = burst_q;
  assign hprot_o       = 4'b0011;
  assign hmasterlock_o = 1'b0;
  assign hstrb_o       = write_q ? 4'hF : 4'h0;
  assign hwdata_o      = hwdata_q;

endmodule
